// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult
// Sequential radix-4 Booth multiplier for signed or unsigned WIDTH-bit
// operands. One Booth digit is retired per clock; the 2*WIDTH-bit product
// and an overflow flag are published when the iteration finishes and are
// held until the next result or reset.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last published result
// RUN   | one Booth iteration per clock; start is ignored here
// DONE  | result_rdy pulse; start here chains straight into a new RUN
module booth_radix4_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] P_hi,
    output logic [WIDTH-1:0] P_lo,
    output logic             overflow
);

    // Number of Booth digits needed to cover the (WIDTH+2)-bit extended multiplier.
    localparam int N  = WIDTH / 2 + 1;
    // Extended operand width: room for a sign bit above unsigned operands, kept even.
    localparam int EW = WIDTH + 2;
    // Accumulator width: extended operand plus headroom for +/-2M partial sums.
    localparam int AW = WIDTH + 4;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [EW-1:0]   mcand_q, mcand_d;
    logic [AW-1:0]   acc_q,   acc_d;
    // Multiplier shift register; bit 0 is the Booth look-behind bit (starts at 0).
    logic [EW:0]     mplr_q,  mplr_d;
    logic            sgn_q,   sgn_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic            ovf_q,   ovf_d;

    logic [AW-1:0]      m_ext;
    logic [AW-1:0]      booth_add;
    logic [AW-1:0]      acc_sum;
    logic [AW-1:0]      acc_shift;
    logic [EW:0]        mplr_shift;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH-1:0]   prod_lo;
    logic               prod_ovf;
    logic               capture;

    function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
        return s ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
    endfunction

    // Booth recoding of the current digit and one accumulate-and-shift step.
    always_comb begin
        m_ext     = {{(AW - EW){mcand_q[EW-1]}}, mcand_q};
        booth_add = '0;
        case (mplr_q[2:0])
            3'b001, 3'b010: booth_add = m_ext;
            3'b011:         booth_add = m_ext << 1;
            3'b100:         booth_add = -(m_ext << 1);
            3'b101, 3'b110: booth_add = -m_ext;
            default:        booth_add = '0;
        endcase
        acc_sum    = acc_q + booth_add;
        acc_shift  = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        mplr_shift = {acc_sum[1:0], mplr_q[EW:2]};
    end

    // Product as it stands after this step; only meaningful on the final digit.
    always_comb begin
        prod     = {acc_shift[WIDTH-3:0], mplr_shift[EW:1]};
        prod_hi  = prod[2*WIDTH-1:WIDTH];
        prod_lo  = prod[WIDTH-1:0];
        prod_ovf = sgn_q ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}})
                         : (prod_hi != '0);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        sgn_d   = sgn_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        ovf_d   = ovf_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    capture = 1'b1;
                end
            end
            RUN: begin
                acc_d  = acc_shift;
                mplr_d = mplr_shift;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    p_hi_d  = prod_hi;
                    p_lo_d  = prod_lo;
                    ovf_d   = prod_ovf;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    capture = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Operands are frozen here; later input changes cannot disturb the run.
        if (capture) begin
            sgn_d   = is_signed;
            mcand_d = extend(A, is_signed);
            mplr_d  = {extend(B, is_signed), 1'b0};
            acc_d   = '0;
            cnt_d   = CW'(N - 1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            sgn_q   <= 1'b0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            sgn_q   <= sgn_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign result_rdy = (state_q == DONE);
    assign P_hi       = p_hi_q;
    assign P_lo       = p_lo_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Scoreboard bench for booth_radix4_mult: a 32-bit instance with random and
// directed runs checked by a decoupled monitor, plus an 8-bit instance with
// directed latency/product checks.
module tb_booth_radix4_mult;

    localparam int W  = 32;
    localparam int N  = W / 2 + 1;
    localparam int W8 = 8;
    localparam int N8 = W8 / 2 + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          start, is_signed;
    logic [W-1:0]  A, B;
    logic          busy, rdy, ovf;
    logic [W-1:0]  P_hi, P_lo;

    logic          start8, s8;
    logic [W8-1:0] A8, B8;
    logic          busy8, rdy8, ovf8;
    logic [W8-1:0] P_hi8, P_lo8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2*W-1:0] p;
        logic           ov;
    } exp_t;

    exp_t           q[$];
    logic [2*W-1:0] hold_p  = '0;
    logic           hold_ov = 1'b0;
    bit             mon_en  = 1'b0;

    always #5 clock = ~clock;

    booth_radix4_mult #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .A(A), .B(B), .busy(busy), .result_rdy(rdy),
        .P_hi(P_hi), .P_lo(P_lo), .overflow(ovf)
    );

    booth_radix4_mult #(.WIDTH(W8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(s8),
        .A(A8), .B(B8), .busy(busy8), .result_rdy(rdy8),
        .P_hi(P_hi8), .P_lo(P_lo8), .overflow(ovf8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Exact arithmetic product and range test, independent of any recoding.
    function automatic exp_t model32(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (s) begin
            longint pr;
            pr   = longint'($signed(a)) * longint'($signed(b));
            e.p  = pr;
            e.ov = (pr > 64'sd2147483647) || (pr < -64'sd2147483648);
        end else begin
            longint unsigned pu;
            pu   = {32'd0, a} * {32'd0, b};
            e.p  = pu;
            e.ov = (pu > 64'h0000_0000_FFFF_FFFF);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Drive start with operands now and enqueue the expected result.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        is_signed = s;
        A         = a;
        B         = b;
        q.push_back(model32(s, a, b));
    endtask

    // After issue: release start, scramble inputs, check N busy cycles then one DONE cycle.
    task automatic expect_run(input string tag);
        @(posedge clock); #1;
        start     = 1'b0;
        A         = $urandom;
        B         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            chk({tag, "_busy"}, {62'd0, busy, rdy}, 64'd2);
        end
        @(negedge clock);
        chk({tag, "_done"}, {62'd0, busy, rdy}, 64'd1);
    endtask

    task automatic run8(input bit s, input logic [W8-1:0] a, input logic [W8-1:0] b);
        int             cyc;
        int             pr;
        logic [15:0]    ep;
        bit             eov;
        @(posedge clock); #1;
        start8 = 1'b1; s8 = s; A8 = a; B8 = b;
        if (s) begin
            pr  = int'($signed(a)) * int'($signed(b));
            eov = (pr > 127) || (pr < -128);
        end else begin
            pr  = int'(a) * int'(b);
            eov = (pr > 255);
        end
        ep = pr[15:0];
        @(posedge clock); #1;
        start8 = 1'b0; s8 = ~s; A8 = ~a; B8 = ~b;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clock);
            if (rdy8) break;
        end
        chk("w8_latency", cyc, N8 + 1);
        chk("w8_product", {P_hi8, P_lo8}, ep);
        chk("w8_overflow", ovf8, eov);
    endtask

    // Monitor: pop and compare at every result pulse, otherwise outputs must hold.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_rdy", rdy, 0);
                end else begin
                    e = q.pop_front();
                    chk("product", {P_hi, P_lo}, e.p);
                    chk("overflow", ovf, e.ov);
                    hold_p  = e.p;
                    hold_ov = e.ov;
                end
            end else begin
                chk("hold_p", {P_hi, P_lo}, hold_p);
                chk("hold_ov", ovf, hold_ov);
            end
            if (reset) begin
                hold_p  = '0;
                hold_ov = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        bad++;
        $display("FAIL timeout: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        start8 = 1'b0; s8 = 1'b0; A8 = '0; B8 = '0;
        repeat (2) @(posedge clock);
        #1;
        mon_en = 1'b1;
        @(negedge clock);
        chk("rst_busy_rdy", {62'd0, busy, rdy}, 64'd0);
        chk("rst_p", {P_hi, P_lo}, 64'd0);
        chk("rst_ovf", ovf, 0);
        chk("rst8_all", {busy8, rdy8, ovf8, P_hi8, P_lo8}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Directed 32-bit cases.
        @(posedge clock); #1; issue(1'b1, -32'sd3, 32'd7);                expect_run("neg3x7");
        @(posedge clock); #1; issue(1'b1, 32'h8000_0000, 32'h8000_0000); expect_run("minxmin");
        @(posedge clock); #1; issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_run("umax");
        @(posedge clock); #1; issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_run("m1xm1");
        // Back-to-back: start held through the DONE cycle.
        issue(1'b0, 32'd5, 32'd6); expect_run("b2b");

        // Random runs, sometimes chained back-to-back.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clock); #1;
            end
            issue(1'($urandom_range(0, 1)), pick(), pick());
            expect_run("rand");
        end

        // start pulsed during RUN is ignored.
        @(posedge clock); #1; issue(1'b1, pick(), pick());
        @(posedge clock); #1; start = 1'b0;
        repeat (3) @(posedge clock);
        #1; start = 1'b1; A = $urandom; B = $urandom; is_signed = 1'b0;
        @(posedge clock); #1; start = 1'b0;
        for (int i = 0; i < N + 4; i++) @(negedge clock);
        chk("ign_busy", busy, 0);
        chk("ign_queue", q.size(), 0);

        // Reset in the middle of a run: no result, everything cleared.
        @(posedge clock); #1; issue(1'b0, pick(), pick());
        @(posedge clock); #1; start = 1'b0;
        repeat (4) @(posedge clock);
        #1; reset = 1'b1;
        void'(q.pop_back());
        @(posedge clock); #1;
        chk("abort_busy_rdy", {62'd0, busy, rdy}, 64'd0);
        chk("abort_p", {P_hi, P_lo}, 64'd0);
        chk("abort_ovf", ovf, 0);
        reset = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clock);
            chk("abort_quiet", {62'd0, busy, rdy}, 64'd0);
        end

        // Reset wins over a simultaneous start.
        @(posedge clock); #1; reset = 1'b1; start = 1'b1; A = 32'd9; B = 32'd9;
        @(posedge clock); #1; reset = 1'b0; start = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clock);
            chk("rst_prio_quiet", {62'd0, busy, rdy}, 64'd0);
        end

        // 8-bit instance.
        run8(1'b0, 8'd200, 8'd3);
        run8(1'b1, 8'h7F, 8'h02);
        run8(1'b1, 8'h80, 8'h80);
        for (int i = 0; i < 8; i++) begin
            run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        repeat (3) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
